// File: rtl/ctech_lib_clk_divider_prog_if.sv
// Ratio-load handshake and run-enable bundle for the programmable clock divider.
// The master requests generation and offers new divide ratios; the slave (divider)
// reports when a captured ratio is waiting and when it has been applied.
interface ctech_lib_clk_divider_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_ratio;
    logic             div_load;
    logic             div_ack;
    logic             load_pend;

    modport master (
        output en,
        output div_ratio,
        output div_load,
        input  div_ack,
        input  load_pend
    );

    modport slave (
        input  en,
        input  div_ratio,
        input  div_load,
        output div_ack,
        output load_pend
    );
endinterface

// File: rtl/ctech_lib_clk_divider_prog.sv
// Programmable integer clock divider with glitch-free ratio switching.
//
// state | meaning
// IDLE  | clkout parked low, counter held at 0, pending ratio applied at once
// RUN   | dividing; every cnt==0 cycle starts a high phase (clkout_rise)
// DRAIN | en dropped mid-period; finish the current period, then park
//
// A new ratio is captured into a holding register and only becomes active in IDLE
// or at the last cycle of a period, so no phase is ever truncated.
module ctech_lib_clk_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    ctech_lib_clk_divider_prog_if.slave        div_if,
    output logic                               clkout,
    output logic                               clkout_rise,
    output logic                               running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_RATIO = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(RESET_RATIO);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_act_q, n_act_d;
    logic [WIDTH-1:0] n_pend_q, n_pend_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             clkout_q, clkout_d;
    logic             rise_q, rise_d;

    logic             wrap;
    logic             apply_pend;
    logic             capture;
    logic [WIDTH-1:0] ratio_in;
    logic [WIDTH-1:0] ratio_clamped;

    // High-phase length (N+1)>>1, computed one bit wider so N = 2^WIDTH-1 does not overflow.
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
        logic [WIDTH:0] s;
        s = {1'b0, n} + {{WIDTH{1'b0}}, 1'b1};
        return s[WIDTH:1];
    endfunction

    assign ratio_in      = div_if.div_ratio;
    assign ratio_clamped = (ratio_in < MIN_RATIO) ? MIN_RATIO : ratio_in;

    // Wrap is only meaningful while counting; in IDLE cnt is 0 and N >= 2, so it stays low.
    assign wrap       = (cnt_q == (n_act_q - ONE));
    assign apply_pend = pend_q && ((state_q == IDLE) || wrap);
    assign capture    = div_if.div_load && !pend_q;

    // Registered state, counter, ratios and all outputs; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_act_q  <= RST_RATIO;
            n_pend_q <= RST_RATIO;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            clkout_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_act_q  <= n_act_d;
            n_pend_q <= n_pend_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            clkout_q <= clkout_d;
            rise_q   <= rise_d;
        end
    end

    // Next-state, ratio handoff and next-cycle output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_act_d  = n_act_q;
        n_pend_d = n_pend_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        clkout_d = 1'b0;
        rise_d   = 1'b0;

        // Apply and capture are mutually exclusive: one needs pend_q set, the other clear.
        // A load arriving on a wrap cycle is therefore held until the next wrap.
        if (apply_pend) begin
            n_act_d = n_pend_q;
            ack_d   = 1'b1;
            pend_d  = 1'b0;
        end
        if (capture) begin
            n_pend_d = ratio_clamped;
            pend_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (div_if.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : (cnt_q + ONE);
                if (!div_if.en) begin
                    state_d = wrap ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = wrap ? '0 : (cnt_q + ONE);
                if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so derive them from the values the next cycle will hold,
        // using the ratio that will be active then.
        if (state_d != IDLE) begin
            clkout_d = (cnt_d < high_len(n_act_d));
        end
        rise_d = (state_d == RUN) && (cnt_d == '0);
    end

    assign clkout           = clkout_q;
    assign clkout_rise      = rise_q;
    assign running          = (state_q != IDLE);
    assign div_if.div_ack   = ack_q;
    assign div_if.load_pend = pend_q;

endmodule

// File: tb/tb_ctech_lib_clk_divider_prog.sv
// Directed bench for the programmable clock divider. Each step drives one cycle of
// stimulus, pushes the hand-derived output vector for the following cycle and then
// pops and compares it against the DUT one time unit after the clock edge.
// Vector layout: {running, clkout, clkout_rise, div_ack, load_pend}.
module tb_ctech_lib_clk_divider_prog;

    localparam int WIDTH = 8;

    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    logic clkout;
    logic clkout_rise;
    logic running;

    int   checks;
    int   errors;
    exp_t sb[$];

    ctech_lib_clk_divider_prog_if #(.WIDTH(WIDTH)) dif ();

    ctech_lib_clk_divider_prog #(
        .WIDTH      (WIDTH),
        .RESET_RATIO(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_if     (dif.slave),
        .clkout     (clkout),
        .clkout_rise(clkout_rise),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Expected vector for a RUN cycle at counter value c with ratio n (no ack, no pend).
    function automatic logic [4:0] run_exp(input int c, input int n);
        logic hi;
        logic rs;
        hi = (c < ((n + 1) / 2));
        rs = (c == 0);
        return {1'b1, hi, rs, 1'b0, 1'b0};
    endfunction

    task automatic step(input logic r, input logic e, input logic ld,
                        input logic [WIDTH-1:0] ratio, input logic [4:0] exp_v,
                        input string tag);
        exp_t       x;
        exp_t       y;
        logic [4:0] obs;
        @(negedge clk);
        rst           = r;
        dif.en        = e;
        dif.div_load  = ld;
        dif.div_ratio = ratio;
        x.v   = exp_v;
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y   = sb.pop_front();
        obs = {running, clkout, clkout_rise, dif.div_ack, dif.load_pend};
        checks++;
        assert (obs === y.v) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", y.tag, obs, y.v);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        dif.en        = 1'b0;
        dif.div_load  = 1'b0;
        dif.div_ratio = '0;

        // Reset state
        step(1, 0, 0, 8'd0, 5'b00000, "reset0");
        step(1, 1, 1, 8'd7, 5'b00000, "reset_prio");
        step(0, 0, 0, 8'd0, 5'b00000, "idle_after_reset");

        // Default ratio 2: 1,0,1,0 with rise on every second cycle; stop at wrap -> IDLE
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'd0, run_exp(i % 2, 2), "n2_run");
        step(0, 0, 0, 8'd0, 5'b00000, "n2_stop_at_wrap");

        // Load 5 in IDLE, ack one cycle after capture, then 1,1,1,0,0
        step(0, 0, 1, 8'd5, 5'b00001, "n5_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "n5_ack");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'd0, run_exp(i % 5, 5), "n5_run");
        step(0, 0, 0, 8'd0, 5'b00000, "n5_stop");

        // Ratio 4, load 6 at cnt=1, second load ignored while pending
        step(0, 0, 1, 8'd4, 5'b00001, "n4_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "n4_ack");
        step(0, 1, 0, 8'd0, 5'b11100, "n4_cnt0");
        step(0, 1, 0, 8'd0, 5'b11000, "n4_cnt1");
        step(0, 1, 1, 8'd6, 5'b10001, "n6_pend_cnt2");
        step(0, 1, 1, 8'd3, 5'b10001, "n6_pend_ignore2nd");
        step(0, 1, 0, 8'd0, 5'b11110, "n6_apply_at_wrap");
        for (int i = 1; i < 12; i++) step(0, 1, 0, 8'd0, run_exp(i % 6, 6), "n6_run");
        step(0, 0, 0, 8'd0, 5'b00000, "n6_stop");

        // Ratio 4, en dropped at cnt=1 -> DRAIN to cnt=3, en in DRAIN ignored
        step(0, 0, 1, 8'd4, 5'b00001, "drain_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "drain_ack");
        step(0, 1, 0, 8'd0, 5'b11100, "drain_cnt0");
        step(0, 1, 0, 8'd0, 5'b11000, "drain_cnt1");
        step(0, 0, 0, 8'd0, 5'b10000, "drain_cnt2");
        step(0, 1, 0, 8'd0, 5'b10000, "drain_cnt3_en_ignored");
        step(0, 1, 0, 8'd0, 5'b00000, "drain_to_idle");
        step(0, 0, 0, 8'd0, 5'b00000, "drain_idle_hold");

        // Load on a wrap cycle is held until the following wrap (ratio 4 -> 2)
        step(0, 1, 0, 8'd0, 5'b11100, "wl_cnt0");
        step(0, 1, 0, 8'd0, 5'b11000, "wl_cnt1");
        step(0, 1, 0, 8'd0, 5'b10000, "wl_cnt2");
        step(0, 1, 0, 8'd0, 5'b10000, "wl_cnt3");
        step(0, 1, 1, 8'd2, 5'b11101, "wl_capture_at_wrap");
        step(0, 1, 0, 8'd0, 5'b11001, "wl_old_n_cnt1");
        step(0, 1, 0, 8'd0, 5'b10001, "wl_old_n_cnt2");
        step(0, 1, 0, 8'd0, 5'b10001, "wl_old_n_cnt3");
        step(0, 1, 0, 8'd0, 5'b11110, "wl_apply_n2");
        step(0, 1, 0, 8'd0, 5'b10000, "wl_n2_cnt1");
        step(0, 0, 0, 8'd0, 5'b00000, "wl_stop");

        // Ratio 255: period 255, high for 128 cycles
        step(0, 0, 1, 8'd255, 5'b00001, "n255_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "n255_ack");
        for (int i = 0; i < 255; i++) step(0, 1, 0, 8'd0, run_exp(i, 255), "n255_run");
        step(0, 0, 0, 8'd0, 5'b00000, "n255_stop");

        // Ratio 0 clamps to 2
        step(0, 0, 1, 8'd0, 5'b00001, "clamp0_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "clamp0_ack");
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'd0, run_exp(i % 2, 2), "clamp0_run");
        step(0, 0, 0, 8'd0, 5'b00000, "clamp0_stop");

        // Ratio 1 clamps to 2 (loaded over ratio 5 so the clamp is visible)
        step(0, 0, 1, 8'd5, 5'b00001, "pre5_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "pre5_ack");
        step(0, 0, 1, 8'd1, 5'b00001, "clamp1_capture");
        step(0, 0, 0, 8'd0, 5'b00010, "clamp1_ack");
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'd0, run_exp(i % 2, 2), "clamp1_run");
        step(0, 0, 0, 8'd0, 5'b00000, "clamp1_stop");

        // Reset at cnt=2 with a load pending: everything cleared, no ack, ratio back to 2
        step(0, 0, 1, 8'd4, 5'b00001, "rst_capture4");
        step(0, 0, 0, 8'd0, 5'b00010, "rst_ack4");
        step(0, 1, 0, 8'd0, 5'b11100, "rst_cnt0");
        step(0, 1, 0, 8'd0, 5'b11000, "rst_cnt1");
        step(0, 1, 1, 8'd6, 5'b10001, "rst_pend_cnt2");
        step(1, 1, 1, 8'd3, 5'b00000, "rst_mid_period");
        step(0, 0, 0, 8'd0, 5'b00000, "rst_no_ack");
        step(0, 1, 0, 8'd0, 5'b11100, "rst_n2_cnt0");
        step(0, 1, 0, 8'd0, 5'b10000, "rst_n2_cnt1");
        step(0, 1, 0, 8'd0, 5'b11100, "rst_n2_cnt0b");
        step(0, 0, 0, 8'd0, 5'b10000, "rst_n2_drain");
        step(0, 0, 0, 8'd0, 5'b00000, "rst_n2_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
